// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
//
// Multicycle control FSM for a MIPS-like datapath. It decodes the latched
// instruction register and the ALU zero flag into every datapath select and
// enable, plus the memory read/write strobes. It also adds a memory wait-state
// handshake, flags illegal instructions and counts retired instructions.
//
// Supported instructions: R-type (add/sub/and/or/slt), lw, sw, beq, addi, j.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-low reset
//   inst_i       in   WIDTH  instruction register (opcode [31:26], funct [5:0])
//   zero_i       in   1      ALU result is zero
//   mem_ready_i  in   1      memory completes the current access this cycle
//   alusrca_o    out  1      ALU A select: 0 = PC, 1 = A register
//   alusrcb_o    out  3      ALU B select: B / 4 / inst / inst<<2 / sign-ext imm
//   alucont_o    out  3      ALU operation
//   pcsource_o   out  2      PC source: ALU / ALU-out / jump target / zero
//   pcen_o       out  1      PC write enable
//   irwrite_o    out  1      instruction register write enable
//   iord_o       out  1      memory address: 0 = PC, 1 = ALU-out
//   regwrite_o   out  1      register file write enable
//   regdst_o     out  1      write address: 0 = rt, 1 = rd
//   memtoreg_o   out  1      write data: 0 = ALU-out, 1 = memory
//   memread_o    out  1      memory read strobe
//   memwrite_o   out  1      memory write strobe
//   illegal_o    out  1      one-cycle pulse on unsupported opcode/funct
//   retired_o    out  WIDTH  completed-instruction counter (wraps)
//
// The state-only part of the control word is registered: it is decoded from
// the next state and loaded on the same edge as the state register, so it is
// exactly the Moore decode of the current state. Only the terms that must
// react within the cycle (reset gating, mem_ready_i in FETCH, zero_i for beq,
// illegal detection on the freshly loaded instruction) are combinational.
// -----------------------------------------------------------------------------
module mc_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inst_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             alusrca_o,
  output logic [2:0]       alusrcb_o,
  output logic [2:0]       alucont_o,
  output logic [1:0]       pcsource_o,
  output logic             pcen_o,
  output logic             irwrite_o,
  output logic             iord_o,
  output logic             regwrite_o,
  output logic             regdst_o,
  output logic             memtoreg_o,
  output logic             memread_o,
  output logic             memwrite_o,
  output logic             illegal_o,
  output logic [WIDTH-1:0] retired_o
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11
  } state_t;

  // Moore control word; pcwrite/pcwritecond are internal and combine into pcen_o.
  typedef struct packed {
    logic       alusrca;
    logic [2:0] alusrcb;
    logic [2:0] alucont;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       pcwritecond;
    logic       irwrite;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = 17'h00000;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  function automatic logic opcode_legal(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic funct_legal(input logic [5:0] fn);
    logic ok;
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Unknown funct leaves the ALU on 000; the instruction is dropped anyway.
  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    logic [2:0] alu;
    case (fn)
      FN_ADD:  alu = ALU_ADD;
      FN_SUB:  alu = ALU_SUB;
      FN_AND:  alu = ALU_AND;
      FN_OR:   alu = ALU_OR;
      FN_SLT:  alu = ALU_SLT;
      default: alu = 3'b000;
    endcase
    return alu;
  endfunction

  function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] fn);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      S_FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = 3'b001;
        c.alucont = ALU_ADD;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      S_DECODE: begin
        c.alusrcb = 3'b011;
        c.alucont = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 3'b100;
        c.alucont = ALU_ADD;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_RTEX: begin
        c.alusrca = 1'b1;
        c.alucont = funct_alu(fn);
      end
      S_RTWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BEQEX: begin
        c.alusrca     = 1'b1;
        c.alucont     = ALU_SUB;
        c.pcsource    = 2'b01;
        c.pcwritecond = 1'b1;
      end
      S_ADDIWB: begin
        c.regwrite = 1'b1;
      end
      S_JEX: begin
        c.pcsource = 2'b10;
        c.pcwrite  = 1'b1;
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_r;
  state_t           state_next_s;
  ctrl_t            ctrl_r;
  logic [WIDTH-1:0] retired_r;
  logic             retire_s;
  logic [5:0]       opcode_s;
  logic [5:0]       funct_s;
  logic             in_fetch_s;
  logic             unused_inst_s;

  assign opcode_s      = inst_i[31:26];
  assign funct_s       = inst_i[5:0];
  assign unused_inst_s = ^inst_i;

  // Next-state selection and retire detection (retire = leaving a final state).
  always_comb begin
    state_next_s = state_r;
    retire_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (mem_ready_i) begin
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode_s)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_RTYPE:     state_next_s = S_RTEX;
          OP_BEQ:       state_next_s = S_BEQEX;
          OP_ADDI:      state_next_s = S_ADDIEX;
          OP_J:         state_next_s = S_JEX;
          default:      state_next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode_s == OP_SW) begin
          state_next_s = S_MEMWR;
        end else begin
          state_next_s = S_MEMRD;
        end
      end
      S_MEMRD: begin
        if (mem_ready_i) begin
          state_next_s = S_MEMWB;
        end else begin
          state_next_s = S_MEMRD;
        end
      end
      S_MEMWR: begin
        if (mem_ready_i) begin
          state_next_s = S_FETCH;
          retire_s     = 1'b1;
        end else begin
          state_next_s = S_MEMWR;
        end
      end
      S_RTEX: begin
        if (funct_legal(funct_s)) begin
          state_next_s = S_RTWB;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_ADDIEX: state_next_s = S_ADDIWB;
      S_MEMWB, S_RTWB, S_BEQEX, S_ADDIWB, S_JEX: begin
        state_next_s = S_FETCH;
        retire_s     = 1'b1;
      end
      default: state_next_s = S_FETCH;
    endcase
  end

  // State register, registered Moore control word and retired counter.
  // The control word for RTEX is loaded while still in DECODE; the IR
  // already holds the instruction there, so funct is valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= S_FETCH;
      ctrl_r    <= decode_ctrl(S_FETCH, funct_s);
      retired_r <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_next_s;
      ctrl_r  <= decode_ctrl(state_next_s, funct_s);
      if (retire_s) begin
        retired_r <= retired_r + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_fetch_s = (state_r == S_FETCH);

  assign alusrca_o  = ctrl_r.alusrca;
  assign alusrcb_o  = ctrl_r.alusrcb;
  assign alucont_o  = ctrl_r.alucont;
  assign pcsource_o = ctrl_r.pcsource;
  assign iord_o     = ctrl_r.iord;
  assign regdst_o   = ctrl_r.regdst;
  assign memtoreg_o = ctrl_r.memtoreg;
  assign retired_o  = retired_r;

  // Enables and strobes are forced low while reset is held so that an
  // interrupted instruction leaves no architectural side effect. The FETCH
  // PC/IR writes only happen on the cycle memory delivers the instruction.
  assign pcen_o     = rst & ((ctrl_r.pcwrite & (~in_fetch_s | mem_ready_i)) |
                             (ctrl_r.pcwritecond & zero_i));
  assign irwrite_o  = rst & ctrl_r.irwrite & mem_ready_i;
  assign regwrite_o = rst & ctrl_r.regwrite;
  assign memread_o  = rst & ctrl_r.memread;
  assign memwrite_o = rst & ctrl_r.memwrite;
  assign illegal_o  = rst & (((state_r == S_DECODE) & ~opcode_legal(opcode_s)) |
                             ((state_r == S_RTEX)   & ~funct_legal(funct_s)));

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
//
// Randomised scoreboard bench. The driver walks each instruction through its
// phase list (taken from the instruction's documented cycle sequence, with
// memory wait cycles inserted) and pushes the expected control outputs and
// retired count for every cycle. A separate monitor pops one entry per cycle
// on the falling edge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_mc_controller;

  localparam int WIDTH = 32;

  typedef logic [17:0] ctl_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] inst_i;
  logic             zero_i;
  logic             mem_ready_i;
  logic             alusrca_o;
  logic [2:0]       alusrcb_o;
  logic [2:0]       alucont_o;
  logic [1:0]       pcsource_o;
  logic             pcen_o;
  logic             irwrite_o;
  logic             iord_o;
  logic             regwrite_o;
  logic             regdst_o;
  logic             memtoreg_o;
  logic             memread_o;
  logic             memwrite_o;
  logic             illegal_o;
  logic [WIDTH-1:0] retired_o;

  mc_controller #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_i      (inst_i),
    .zero_i      (zero_i),
    .mem_ready_i (mem_ready_i),
    .alusrca_o   (alusrca_o),
    .alusrcb_o   (alusrcb_o),
    .alucont_o   (alucont_o),
    .pcsource_o  (pcsource_o),
    .pcen_o      (pcen_o),
    .irwrite_o   (irwrite_o),
    .iord_o      (iord_o),
    .regwrite_o  (regwrite_o),
    .regdst_o    (regdst_o),
    .memtoreg_o  (memtoreg_o),
    .memread_o   (memread_o),
    .memwrite_o  (memwrite_o),
    .illegal_o   (illegal_o),
    .retired_o   (retired_o)
  );

  always #5 clk = ~clk;

  // Scoreboard state
  logic [49:0]  exp_q[$];
  string        tag_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc_no = 0;
  logic [31:0]  ret_model;
  logic [31:0]  ir_q;

  ctl_t         act_ctl;
  logic [49:0]  mon_exp;
  string        mon_tag;

  assign act_ctl = {alusrca_o, alusrcb_o, alucont_o, pcsource_o, pcen_o, irwrite_o,
                    iord_o, regwrite_o, regdst_o, memtoreg_o, memread_o, memwrite_o,
                    illegal_o};

  // Expected control vector, fields in the same order as act_ctl.
  function automatic ctl_t mk(input logic a, input logic [2:0] b, input logic [2:0] alu,
                              input logic [1:0] pcs, input logic pcen, input logic irw,
                              input logic iord, input logic rw, input logic rdst,
                              input logic m2r, input logic mr, input logic mw,
                              input logic ill);
    return {a, b, alu, pcs, pcen, irw, iord, rw, rdst, m2r, mr, mw, ill};
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
  endfunction

  function automatic logic legal_fn(input logic [5:0] fn);
    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  // Monitor: one comparison per cycle whenever an expectation is pending.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      n_cmp++;
      if ({act_ctl, retired_o} !== mon_exp) begin
        n_err++;
        $display("FAIL %s (cycle %0d): got ctl=%05h retired=%0d, expected ctl=%05h retired=%0d",
                 mon_tag, cyc_no, act_ctl, retired_o, mon_exp[49:32], mon_exp[31:0]);
      end
    end
  end

  // Drive one cycle of inputs and record what the outputs must be in it.
  task automatic cyc(input string tag, input ctl_t e, input logic rdy,
                     input logic z, input logic r);
    @(posedge clk);
    #1;
    cyc_no++;
    rst         = r;
    mem_ready_i = rdy;
    zero_i      = z;
    inst_i      = ir_q;
    exp_q.push_back({e, ret_model});
    tag_q.push_back(tag);
  endtask

  task automatic fetch_phase(input logic [31:0] inst, input int fw);
    for (int i = 0; i < fw; i++)
      cyc("fetch_wait", mk(1'b0, 3'b001, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b1, 1'b0, 1'b0), 1'b0, rbit(), 1'b1);
    cyc("fetch", mk(1'b0, 3'b001, 3'b010, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b0, 1'b0), 1'b1, rbit(), 1'b1);
    ir_q = inst;
  endtask

  // Reference model for one instruction: fw FETCH waits, mw memory waits.
  task automatic run_inst(input logic [31:0] inst, input int fw, input int mw, input logic z);
    logic [5:0] op;
    logic [5:0] fn;
    op = inst[31:26];
    fn = inst[5:0];
    fetch_phase(inst, fw);
    cyc("decode", mk(1'b0, 3'b011, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, !legal_op(op)), rbit(), rbit(), 1'b1);
    if (!legal_op(op)) return;
    case (op)
      6'h23: begin
        cyc("memadr", mk(1'b1, 3'b100, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0), rbit(), rbit(), 1'b1);
        for (int i = 0; i < mw; i++)
          cyc("memrd_wait", mk(1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b0), 1'b0, rbit(), 1'b1);
        cyc("memrd", mk(1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                        1'b0, 1'b1, 1'b0, 1'b0), 1'b1, rbit(), 1'b1);
        cyc("memwb", mk(1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                        1'b1, 1'b0, 1'b0, 1'b0), rbit(), rbit(), 1'b1);
        ret_model++;
      end
      6'h2B: begin
        cyc("memadr", mk(1'b1, 3'b100, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0), rbit(), rbit(), 1'b1);
        for (int i = 0; i < mw; i++)
          cyc("memwr_wait", mk(1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b1, 1'b0), 1'b0, rbit(), 1'b1);
        cyc("memwr", mk(1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                        1'b0, 1'b0, 1'b1, 1'b0), 1'b1, rbit(), 1'b1);
        ret_model++;
      end
      6'h00: begin
        cyc("rtex", mk(1'b1, 3'b000, alu_of(fn), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                       1'b0, 1'b0, 1'b0, !legal_fn(fn)), rbit(), rbit(), 1'b1);
        if (legal_fn(fn)) begin
          cyc("rtwb", mk(1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                         1'b0, 1'b0, 1'b0, 1'b0), rbit(), rbit(), 1'b1);
          ret_model++;
        end
      end
      6'h04: begin
        cyc("beqex", mk(1'b1, 3'b000, 3'b110, 2'b01, z, 1'b0, 1'b0, 1'b0, 1'b0,
                        1'b0, 1'b0, 1'b0, 1'b0), rbit(), z, 1'b1);
        ret_model++;
      end
      6'h08: begin
        cyc("addiex", mk(1'b1, 3'b100, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0), rbit(), rbit(), 1'b1);
        cyc("addiwb", mk(1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                         1'b0, 1'b0, 1'b0, 1'b0), rbit(), rbit(), 1'b1);
        ret_model++;
      end
      6'h02: begin
        cyc("jex", mk(1'b0, 3'b000, 3'b000, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b0, 1'b0), rbit(), rbit(), 1'b1);
        ret_model++;
      end
      default: ;
    endcase
  endtask

  // sw interrupted by reset while the memory is still stalling the write.
  task automatic sw_with_reset(input logic [31:0] inst);
    fetch_phase(inst, 0);
    cyc("decode", mk(1'b0, 3'b011, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0), rbit(), rbit(), 1'b1);
    cyc("memadr", mk(1'b1, 3'b100, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0, 1'b0), rbit(), rbit(), 1'b1);
    cyc("memwr_wait", mk(1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b1, 1'b0), 1'b0, rbit(), 1'b1);
    cyc("memwr_in_reset", mk(1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, 1'b0);
    ret_model = 32'd0;
  endtask

  initial begin
    logic [31:0] r;
    logic [5:0]  op;
    logic [5:0]  fn;
    int          kind;

    rst         = 1'b0;
    mem_ready_i = 1'b0;
    zero_i      = 1'b0;
    inst_i      = 32'h0;
    ir_q        = 32'h0;
    ret_model   = 32'd0;

    // First edge puts the FSM in a known state; then three checked reset cycles.
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      cyc("reset", mk(1'b0, 3'b001, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b0, 1'b0), rbit(), rbit(), 1'b0);

    // Directed cases
    run_inst(32'h20080005, 0, 0, 1'b0);   // addi
    run_inst(32'h8C090000, 0, 2, 1'b0);   // lw, 2 wait states in MEMRD
    run_inst(32'h11090003, 0, 0, 1'b1);   // beq taken
    run_inst(32'h11090003, 0, 0, 1'b0);   // beq not taken
    run_inst(32'hFC000000, 0, 0, 1'b0);   // illegal opcode
    run_inst(32'h0000003F, 0, 0, 1'b0);   // R-type, illegal funct
    run_inst(32'h012A4020, 1, 0, 1'b0);   // add with a fetch wait
    run_inst(32'h08000010, 0, 0, 1'b0);   // j
    run_inst(32'hAC090004, 0, 1, 1'b0);   // sw with one write wait
    sw_with_reset(32'hAC090000);
    run_inst(32'h20080005, 0, 0, 1'b0);   // addi after mid-instruction reset

    // Randomised instruction stream
    for (int n = 0; n < 300; n++) begin
      r    = $urandom();
      kind = $urandom_range(7, 0);
      fn   = r[5:0];
      case (kind)
        0: op = 6'h23;
        1: op = 6'h2B;
        2: begin
          op = 6'h00;
          case ($urandom_range(4, 0))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            default: fn = 6'h2A;
          endcase
        end
        3: op = 6'h04;
        4: op = 6'h08;
        5: op = 6'h02;
        6: begin
          op = 6'($urandom_range(63, 0));
          while (legal_op(op)) op = 6'($urandom_range(63, 0));
        end
        default: begin
          op = 6'h00;
          while (legal_fn(fn)) fn = 6'($urandom_range(63, 0));
        end
      endcase
      run_inst({op, r[25:6], fn}, $urandom_range(2, 0), $urandom_range(3, 0), rbit());
    end

    // Every pushed expectation must have been consumed by the monitor.
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control FSM driving the datapath: takes the latched instruction and the zero flag, and generates every datapath select/enable plus the memory read/write strobes.
- Sits directly upstream of the datapath. Its outputs connect one-to-one to the datapath control inputs. inst_i and zero_i come back from the datapath.
- Supports R-type (add/sub/and/or/slt), lw, sw, beq, addi and j.
- Adds memory wait-state handshake, illegal-opcode flagging and a retired-instruction counter.

Parameters:
- WIDTH, 32, instruction width and width of the retired-instruction counter.

Ports:
- clk  in  1  clock; everything updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- inst_i  in  WIDTH  instruction register contents; opcode = [31:26], funct = [5:0].
- zero_i  in  1  ALU-result-is-zero flag, combinational from the datapath.
- mem_ready_i  in  1  memory completes the current access this cycle.
- alusrca_o  out  1  0 = PC, 1 = A register.
- alusrcb_o  out  3  000 = B, 001 = const 4, 010 = raw instruction, 011 = instruction<<2, 100 = sign-extended immediate.
- alucont_o  out  3  010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
- pcsource_o  out  2  00 = ALU result, 01 = ALU-out register, 10 = jump target (instruction<<2), 11 = zero.
- pcen_o  out  1  PC write enable.
- irwrite_o  out  1  instruction register write enable.
- iord_o  out  1  memory address select: 0 = PC, 1 = ALU-out.
- regwrite_o  out  1  register file write enable.
- regdst_o  out  1  write address select: 0 = rt, 1 = rd.
- memtoreg_o  out  1  write data select: 0 = ALU-out, 1 = memory.
- memread_o  out  1  memory read strobe.
- memwrite_o  out  1  memory write strobe.
- illegal_o  out  1  one-cycle pulse on an unsupported opcode or funct.
- retired_o  out  WIDTH  count of completed instructions.

Behaviour:
- State register is one-hot or binary (implementer's choice). States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB, BEQEX, ADDIEX, ADDIWB, JEX.
- Reset: while rst is 0 at a clock edge, state <= FETCH and retired_o <= 0.
  - While rst is low, pcen_o, irwrite_o, regwrite_o, memread_o, memwrite_o and illegal_o are forced to 0 combinationally.
  - Reset asserted mid-instruction aborts it: no register write, no PC write, no count.
- Output style: all outputs are Moore, decoded from state, with two exceptions:
  - pcen_o = pcwrite | (pcwritecond & zero_i).
  - The FETCH strobes are gated by mem_ready_i.
  - Selects not listed for a state are 0, with alusrcb_o = 000.
- FETCH:
  - memread_o = 1, iord_o = 0, alusrca_o = 0, alusrcb_o = 001, alucont_o = add, pcsource_o = 00.
  - irwrite_o and pcwrite = mem_ready_i.
  - Stay in FETCH while mem_ready_i = 0; go to DECODE when it is 1.
- DECODE:
  - alusrca_o = 0, alusrcb_o = 011, alucont_o = add.
  - Next state by opcode: lw/sw -> MEMADR; 000000 -> RTEX; beq -> BEQEX; addi -> ADDIEX; j -> JEX.
  - Any other opcode: illegal_o = 1 for this cycle, next state FETCH.
- MEMADR: alusrca_o = 1, alusrcb_o = 100, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD:
  - memread_o = 1, iord_o = 1.
  - Wait while mem_ready_i = 0; go to MEMWB when it is 1.
- MEMWB: regwrite_o = 1, memtoreg_o = 1, regdst_o = 0. Retire; next state FETCH.
- MEMWR:
  - memwrite_o = 1, iord_o = 1; held high for every cycle until mem_ready_i = 1.
  - On mem_ready_i = 1: retire, next state FETCH.
- RTEX:
  - alusrca_o = 1, alusrcb_o = 000.
  - alucont_o from funct: 100000 = add, 100010 = sub, 100100 = and, 100101 = or, 101010 = slt.
  - Unknown funct: illegal_o = 1, next state FETCH, no write.
  - Otherwise next state RTWB.
- RTWB: regwrite_o = 1, regdst_o = 1, memtoreg_o = 0. Retire; next state FETCH.
- BEQEX:
  - alusrca_o = 1, alusrcb_o = 000, sub, pcsource_o = 01, pcwritecond = 1.
  - Retire whether or not the branch is taken; next state FETCH.
- ADDIEX: alusrca_o = 1, alusrcb_o = 100, add. Next state ADDIWB.
- ADDIWB: regwrite_o = 1, regdst_o = 0. Retire; next state FETCH.
- JEX: pcsource_o = 10, pcwrite = 1. Retire; next state FETCH.
- Cycle counts with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each cycle of mem_ready_i = 0 in FETCH, MEMRD or MEMWR adds one cycle.
- retired_o:
  - Increments by 1 on the clock edge that leaves a retiring state.
  - Wraps from all-ones to 0.
  - Illegal instructions do not count.

Test Plan:
- Reset: hold rst = 0 for 3 cycles, then release.
  - During reset, all enables/strobes read 0 and retired_o = 0.
  - Cycle after release: FETCH with memread_o = 1.
- addi, inst_i = 0x20080005, mem_ready_i always 1.
  - Sequence FETCH, DECODE, ADDIEX, ADDIWB.
  - regwrite_o = 1 only in cycle 4, with regdst_o = 0; retired_o = 1 afterwards.
- lw 0x8C090000 with mem_ready_i = 0 for 2 cycles in MEMRD.
  - Instruction takes 7 cycles; memread_o and iord_o stay 1 through the wait.
  - MEMWB has memtoreg_o = 1.
- beq 0x11090003.
  - zero_i = 1: pcen_o = 1 in BEQEX with pcsource_o = 01.
  - zero_i = 0: pcen_o = 0.
  - retired_o increments in both cases.
- Illegal opcode 0xFC000000: illegal_o pulses in DECODE, next state FETCH, retired_o unchanged.
  - R-type with funct 0x3F: illegal_o pulses in RTEX, no regwrite_o.
- Drive rst = 0 during MEMWR (sw, mem_ready_i = 0).
  - memwrite_o drops immediately; FETCH next cycle; retired_o = 0.
